reciprocal_fx: RTL and testbench

- Signed fixed-point reciprocal unit, Qm.n format (M integer bits including sign, N fractional bits, W = M+N total).
- Computes 1/x with optional absolute-value mode and a saturation flag.
- Used by the ray tracer for three jobs: per-axis step distances (1/|rayDir|) and wall height scale (1/|visualWallDist|).
- Combinational core followed by one output register stage.

---
 rtl/reciprocal_fx_pkg.sv | 25 ++
 rtl/reciprocal_fx_if.sv | 28 ++
 rtl/reciprocal_fx_core.sv | 41 ++++
 rtl/reciprocal_fx.sv | 62 ++++++
 tb/tb_reciprocal_fx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/reciprocal_fx_pkg.sv
// Fixed-point defaults and helpers shared by the reciprocal unit.
// Qm.n with sign included in the integer bits.
package reciprocal_fx_pkg;

  localparam int Q_M = 6;
  localparam int Q_N = 10;
  localparam int Q_W = Q_M + Q_N;

  function automatic int max_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int int_to_f(input int v, input int n);
    return v <<< n;
  endfunction

  function automatic int f_to_int(input int v, input int n);
    return v >>> n;
  endfunction

  function automatic int frac(input int v, input int n);
    return v & ((1 << n) - 1);
  endfunction

endpackage

// File: rtl/reciprocal_fx_if.sv
// Operand/result bundle of the reciprocal unit.
// No handshake: the unit accepts a new operand every cycle.
interface reciprocal_fx_if
  import reciprocal_fx_pkg::*;
#(
  parameter int W = Q_W
);

  logic signed [W-1:0] i_data;
  logic                i_abs;
  logic signed [W-1:0] o_data;
  logic                o_sat;

  modport master (
    output i_data,
    output i_abs,
    input  o_data,
    input  o_sat
  );

  modport slave (
    input  i_data,
    input  i_abs,
    output o_data,
    output o_sat
  );

endinterface

// File: rtl/reciprocal_fx_core.sv
// Combinational restoring divider: floor(2^(2N) / mag).
// Clamps to the max positive code and flags overflow.
module recip_core #(
  parameter int W = 16,
  parameter int N = 10
) (
  input  logic [W:0]   i_mag,
  output logic [W-1:0] o_quot,
  output logic         o_ovf
);

  localparam int DW = 2 * N + 1;
  localparam int QL = (DW > W) ? DW : W;
  localparam int RW = W + 2;
  localparam logic [W-1:0] MAXP =
    {1'b0, {(W-1){1'b1}}};

  logic [QL-1:0] q;
  logic [RW-1:0] rem;
  logic [RW-1:0] den;

  // dividend is a single one at bit 2N
  always_comb begin
    q   = '0;
    rem = '0;
    den = {1'b0, i_mag};
    for (int i = QL - 1; i >= 0; i--) begin
      rem = {rem[RW-2:0], (i == 2 * N)};
      if (rem >= den) begin
        rem  = rem - den;
        q[i] = 1'b1;
      end
    end
  end

  always_comb begin
    o_ovf  = (i_mag == '0) || (|(q >> (W - 1)));
    o_quot = o_ovf ? MAXP : q[W-1:0];
  end

endmodule

// File: rtl/reciprocal_fx.sv
// Signed Qm.n reciprocal with abs mode and saturation flag.
// One registered output stage, one result per cycle.
module reciprocal_fx
  import reciprocal_fx_pkg::*;
#(
  parameter int M = Q_M,
  parameter int N = Q_N
) (
  input  logic            clk,
  input  logic            reset,
  reciprocal_fx_if.slave  bus
);

  localparam int W = M + N;

  if (N < 8 || M < 2) begin : g_bad_fmt
    $error("reciprocal_fx: need N >= 8 and M >= 2");
  end

  logic         neg;
  logic [W:0]   x_ext;
  logic [W:0]   mag;
  logic [W-1:0] quot;
  logic         ovf;
  logic [W-1:0] data_d, data_q;
  logic         sat_d, sat_q;

  // W+1 bits so -2^(W-1) has a representable magnitude
  always_comb begin
    neg   = bus.i_data[W-1];
    x_ext = {neg, bus.i_data};
    mag   = neg ? -x_ext : x_ext;
  end

  recip_core #(
    .W (W),
    .N (N)
  ) u_core (
    .i_mag  (mag),
    .o_quot (quot),
    .o_ovf  (ovf)
  );

  always_comb begin
    data_d = (neg && !bus.i_abs) ? -quot : quot;
    sat_d  = ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_sat  = sat_q;

endmodule

// File: tb/tb_reciprocal_fx.sv
// Self-checking bench for reciprocal_fx (M=6, N=10).
module tb_reciprocal_fx;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  reciprocal_fx_if #(.W(16)) bus ();

  reciprocal_fx #(.M(6), .N(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic signed [15:0] x,
    input  logic               ab,
    output logic signed [15:0] d,
    output logic               s
  );
    longint a, q, m;
    a = (x < 0) ? -longint'(x) : longint'(x);
    q = (a == 0) ? 64'd1 << 40 : (longint'(1) << 20) / a;
    s = (a == 0) || (q > 32767);
    m = s ? 32767 : q;
    d = (x < 0 && !ab) ? 16'(-m) : 16'(m);
  endfunction

  task automatic drive(input logic signed [15:0] x, input logic ab);
    @(negedge clk);
    bus.i_data = x;
    bus.i_abs  = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    bus.i_data = 16'sd1024;
    bus.i_abs  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (bus.o_data !== 16'sd0 || bus.o_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_hold data=%0d sat=%0b want 0/0",
               bus.o_data, bus.o_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (bus.o_data !== 16'sd1024 || bus.o_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release data=%0d sat=%0b want 1024/0",
               bus.o_data, bus.o_sat);
    end
  endtask

  task automatic test_exact;
    logic signed [15:0] xin [6] = '{1024, 2048, 512, 768, 33, 32767};
    logic signed [15:0] xout[6] = '{1024, 512, 2048, 1365, 31775, 32};
    for (int i = 0; i < 6; i++) begin
      drive(xin[i], 1'b1);
      vec_cnt++;
      if (bus.o_data !== xout[i] || bus.o_sat !== 1'b0) begin
        err_cnt++;
        $display("FAIL exact x=%0d data=%0d sat=%0b want %0d/0",
                 xin[i], bus.o_data, bus.o_sat, xout[i]);
      end
    end
  endtask

  task automatic test_sign;
    logic signed [15:0] xin [4] = '{-1024, -1024, -768, -32768};
    logic               ain [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic signed [15:0] xout[4] = '{-1024, 1024, -1365, 32};
    for (int i = 0; i < 4; i++) begin
      drive(xin[i], ain[i]);
      vec_cnt++;
      if (bus.o_data !== xout[i] || bus.o_sat !== 1'b0) begin
        err_cnt++;
        $display("FAIL sign x=%0d abs=%0b data=%0d sat=%0b want %0d/0",
                 xin[i], ain[i], bus.o_data, bus.o_sat, xout[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic signed [15:0] xin [5] = '{0, 0, 32, 1, -32};
    logic               ain [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic signed [15:0] xout[5] = '{32767, 32767, 32767, 32767, -32767};
    for (int i = 0; i < 5; i++) begin
      drive(xin[i], ain[i]);
      vec_cnt++;
      if (bus.o_data !== xout[i] || bus.o_sat !== 1'b1) begin
        err_cnt++;
        $display("FAIL sat x=%0d abs=%0b data=%0d sat=%0b want %0d/1",
                 xin[i], ain[i], bus.o_data, bus.o_sat, xout[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      drive(i[0] ? 16'sd0 : 16'sd2048, 1'b0);
      vec_cnt++;
      if (i[0]) begin
        if (bus.o_data !== 16'sd32767 || bus.o_sat !== 1'b1) begin
          err_cnt++;
          $display("FAIL b2b_zero data=%0d sat=%0b want 32767/1",
                   bus.o_data, bus.o_sat);
        end
      end else begin
        if (bus.o_data !== 16'sd512 || bus.o_sat !== 1'b0) begin
          err_cnt++;
          $display("FAIL b2b_2048 data=%0d sat=%0b want 512/0",
                   bus.o_data, bus.o_sat);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    drive(16'sd0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.o_data !== 16'sd0 || bus.o_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset data=%0d sat=%0b want 0/0",
               bus.o_data, bus.o_sat);
    end
    drive(16'sd512, 1'b1);
    vec_cnt++;
    if (bus.o_data !== 16'sd0 || bus.o_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_held_edge data=%0d sat=%0b want 0/0",
               bus.o_data, bus.o_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'sd512, 1'b1);
    vec_cnt++;
    if (bus.o_data !== 16'sd2048 || bus.o_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL after_reset data=%0d sat=%0b want 2048/0",
               bus.o_data, bus.o_sat);
    end
  endtask

  task automatic test_random;
    logic signed [15:0] x, ed;
    logic               ab, es;
    for (int i = 0; i < 10000; i++) begin
      x  = 16'($urandom);
      if (i % 4 == 0) x = 16'($signed(12'($urandom)));
      ab = 1'($urandom_range(0, 1));
      model(x, ab, ed, es);
      drive(x, ab);
      vec_cnt++;
      if (bus.o_data !== ed || bus.o_sat !== es) begin
        err_cnt++;
        $display("FAIL random x=%0d abs=%0b data=%0d sat=%0b want %0d/%0b",
                 x, ab, bus.o_data, bus.o_sat, ed, es);
      end
    end
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst_n      = 1'b0;
    bus.i_data = '0;
    bus.i_abs  = 1'b0;
    test_reset();
    test_exact();
    test_sign();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
